// File: rtl/ntt_basemul_pkg.sv
// ntt_basemul_pkg
//   Shared Kyber constants for the NTT-domain base-case multiplier: modulus,
//   coefficient sizes, pipeline depth, Barrett reduction constants and the
//   controller state type.
//   No ports (package).
package ntt_basemul_pkg;

    localparam int KYBER_N  = 256;
    localparam int COEF_W   = 16;
    localparam int DEPTH    = 8;
    localparam int PAIRS    = 2 ** (DEPTH - 1);
    localparam int PIPE_LAT = 6;

    localparam logic [11:0] KYBER_Q = 12'd3329;

    // Barrett reduction for inputs below 2^25: quotient estimate is
    // (x * floor(2^26 / q)) >> 26, which undershoots by at most 2.
    localparam int          RED_W         = 25;
    localparam int          BARRETT_SHIFT = 26;
    localparam logic [14:0] BARRETT_M     = 15'd20158;

    localparam logic [DEPTH-2:0] LAST_PAIR = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bm_state_t;

endpackage

// File: rtl/ntt_basemul_if.sv
// ntt_basemul_if
//   Bundles the control handshake and the memory-side buses of ntt_basemul.
//   Signals:
//     start/busy/done               control handshake
//     src_addr_1/2, a_dout_*, b_dout_*  operand RAM read ports (shared address)
//     gamma_addr/gamma_data         gamma ROM read port
//     r_we, r_addr_1/2, r_din_1/2   result RAM write ports
//   Modports: master = multiplier side, slave = environment (RAMs, ROM, host).
interface ntt_basemul_if;
    import ntt_basemul_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [DEPTH-1:0]     src_addr_1;
    logic [DEPTH-1:0]     src_addr_2;
    logic [COEF_W-1:0]    a_dout_1;
    logic [COEF_W-1:0]    a_dout_2;
    logic [COEF_W-1:0]    b_dout_1;
    logic [COEF_W-1:0]    b_dout_2;
    logic [DEPTH-2:0]     gamma_addr;
    logic [COEF_W-1:0]    gamma_data;
    logic                 r_we;
    logic [DEPTH-1:0]     r_addr_1;
    logic [DEPTH-1:0]     r_addr_2;
    logic [COEF_W-1:0]    r_din_1;
    logic [COEF_W-1:0]    r_din_2;

    modport master (
        input  start, a_dout_1, a_dout_2, b_dout_1, b_dout_2, gamma_data,
        output busy, done, src_addr_1, src_addr_2, gamma_addr,
               r_we, r_addr_1, r_addr_2, r_din_1, r_din_2
    );

    modport slave (
        output start, a_dout_1, a_dout_2, b_dout_1, b_dout_2, gamma_data,
        input  busy, done, src_addr_1, src_addr_2, gamma_addr,
               r_we, r_addr_1, r_addr_2, r_din_1, r_din_2
    );

endinterface

// File: rtl/ntt_basemul_mod_q_reduce.sv
// mod_q_reduce
//   Combinational exact reduction x mod 3329 for any 25-bit unsigned x.
//   Ports:
//     din   in  25  value to reduce
//     dout  out 12  din mod q, in [0, q)
module mod_q_reduce
    import ntt_basemul_pkg::*;
(
    input  logic [RED_W-1:0] din,
    output logic [11:0]      dout
);

    localparam logic [13:0] Q14 = {2'b00, KYBER_Q};

    logic [39:0] est_prod;
    logic [13:0] quot;
    logic [13:0] rem0;
    logic [13:0] rem1;
    logic [13:0] rem2;

    // Barrett estimate, then at most two corrective subtractions. The true
    // remainder after the estimate is below 3q, so 14-bit wrap-around
    // arithmetic on the low bits is exact.
    always_comb begin
        est_prod = {15'd0, din} * {25'd0, BARRETT_M};
        quot     = 14'(est_prod >> BARRETT_SHIFT);
        rem0     = din[13:0] - quot * Q14;
        rem1     = (rem0 >= Q14) ? rem0 - Q14 : rem0;
        rem2     = (rem1 >= Q14) ? rem1 - Q14 : rem1;
        dout     = 12'(rem2);
    end

endmodule

// File: rtl/ntt_basemul.sv
// ntt_basemul
//   Pointwise base-case multiplier for NTT-domain Kyber polynomials. For each
//   pair i: c[2i]   = a0*b0 + a1*b1*gamma_i  (mod q)
//           c[2i+1] = a0*b1 + a1*b0          (mod q)
//   One pair is issued per cycle; results are written 6 cycles after issue.
//   Ports:
//     clk    in  clock
//     reset  in  asynchronous, active-high reset
//     bus    ntt_basemul_if.master: start/busy/done, operand RAM and gamma
//            ROM read ports, result RAM write ports
module ntt_basemul
    import ntt_basemul_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ntt_basemul_if.master bus
);

    bm_state_t state;
    bm_state_t state_next;

    logic [DEPTH-2:0] pair_cnt;
    logic [DEPTH-2:0] pair_next;
    logic             pair_load;
    logic             issue_valid;
    logic             last_write;

    logic [DEPTH-1:0] src_addr_1_q;
    logic [DEPTH-1:0] src_addr_2_q;
    logic [DEPTH-2:0] gamma_addr_q;

    logic [PIPE_LAT:1] valid_pipe;
    logic [DEPTH-2:0]  idx_pipe [1:PIPE_LAT-1];

    logic [11:0] a0, a1, b0, b1, g1;

    logic [23:0] s2_p00, s2_p11, s2_p01, s2_p10;
    logic [11:0] s2_gamma;
    logic [11:0] s3_r11, s3_gamma;
    logic [23:0] s3_p00;
    logic [24:0] s3_cross;
    logic [23:0] s4_gp, s4_p00;
    logic [24:0] s4_cross;
    logic [24:0] s5_sum, s5_cross;

    logic [11:0] red_p11, red_sum, red_cross;

    logic [DEPTH-1:0]  r_addr_1_q, r_addr_2_q;
    logic [COEF_W-1:0] r_din_1_q, r_din_2_q;

    logic unused_hi;

    // Stage 1 is the operand capture done by the synchronous RAM/ROM output
    // registers; only the low 12 bits of each canonical coefficient matter.
    assign a0 = bus.a_dout_1[11:0];
    assign a1 = bus.a_dout_2[11:0];
    assign b0 = bus.b_dout_1[11:0];
    assign b1 = bus.b_dout_2[11:0];
    assign g1 = bus.gamma_data[11:0];
    assign unused_hi = ^{bus.a_dout_1[15:12], bus.a_dout_2[15:12],
                         bus.b_dout_1[15:12], bus.b_dout_2[15:12],
                         bus.gamma_data[15:12]};

    assign issue_valid = (state == ST_RUN);
    assign last_write  = (r_addr_1_q == {LAST_PAIR, 1'b0});

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Start is honoured only in IDLE; RUN issues one pair
    // per cycle and DRAIN waits for the final pair to reach the write stage.
    always_comb begin
        state_next = state;
        pair_load  = 1'b0;
        pair_next  = pair_cnt + 7'd1;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    pair_load  = 1'b1;
                    pair_next  = '0;
                end
            end
            ST_RUN: begin
                if (pair_cnt == LAST_PAIR) begin
                    state_next = ST_DRAIN;
                end else begin
                    pair_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (valid_pipe[PIPE_LAT] && last_write) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pair counter and registered read addresses for the pair being issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_cnt     <= '0;
            src_addr_1_q <= '0;
            src_addr_2_q <= '0;
            gamma_addr_q <= '0;
        end else if (pair_load) begin
            pair_cnt     <= pair_next;
            src_addr_1_q <= {pair_next, 1'b0};
            src_addr_2_q <= {pair_next, 1'b1};
            gamma_addr_q <= pair_next;
        end
    end

    // Valid bit and pair index travel alongside the data so the write stage
    // needs no knowledge of the controller state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            for (int k = 1; k < PIPE_LAT; k++) begin
                idx_pipe[k] <= '0;
            end
        end else begin
            valid_pipe  <= {valid_pipe[PIPE_LAT-1:1], issue_valid};
            idx_pipe[1] <= pair_cnt;
            for (int k = 2; k < PIPE_LAT; k++) begin
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    mod_q_reduce u_red_p11   (.din({1'b0, s2_p11}), .dout(red_p11));
    mod_q_reduce u_red_sum   (.din(s5_sum),         .dout(red_sum));
    mod_q_reduce u_red_cross (.din(s5_cross),       .dout(red_cross));

    // Arithmetic stages S2..S6. a1*b1 is reduced before the gamma multiply so
    // that product stays 24 bits; both final sums stay below 2^25.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_p00     <= '0;
            s2_p11     <= '0;
            s2_p01     <= '0;
            s2_p10     <= '0;
            s2_gamma   <= '0;
            s3_r11     <= '0;
            s3_gamma   <= '0;
            s3_p00     <= '0;
            s3_cross   <= '0;
            s4_gp      <= '0;
            s4_p00     <= '0;
            s4_cross   <= '0;
            s5_sum     <= '0;
            s5_cross   <= '0;
            r_addr_1_q <= '0;
            r_addr_2_q <= '0;
            r_din_1_q  <= '0;
            r_din_2_q  <= '0;
        end else begin
            s2_p00     <= {12'd0, a0} * {12'd0, b0};
            s2_p11     <= {12'd0, a1} * {12'd0, b1};
            s2_p01     <= {12'd0, a0} * {12'd0, b1};
            s2_p10     <= {12'd0, a1} * {12'd0, b0};
            s2_gamma   <= g1;

            s3_r11     <= red_p11;
            s3_gamma   <= s2_gamma;
            s3_p00     <= s2_p00;
            s3_cross   <= {1'b0, s2_p01} + {1'b0, s2_p10};

            s4_gp      <= {12'd0, s3_r11} * {12'd0, s3_gamma};
            s4_p00     <= s3_p00;
            s4_cross   <= s3_cross;

            s5_sum     <= {1'b0, s4_p00} + {1'b0, s4_gp};
            s5_cross   <= s4_cross;

            r_addr_1_q <= {idx_pipe[PIPE_LAT-1], 1'b0};
            r_addr_2_q <= {idx_pipe[PIPE_LAT-1], 1'b1};
            r_din_1_q  <= {4'd0, red_sum};
            r_din_2_q  <= {4'd0, red_cross};
        end
    end

    assign bus.busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.done       = (state == ST_DONE);
    assign bus.src_addr_1 = src_addr_1_q;
    assign bus.src_addr_2 = src_addr_2_q;
    assign bus.gamma_addr = gamma_addr_q;
    assign bus.r_we       = valid_pipe[PIPE_LAT];
    assign bus.r_addr_1   = r_addr_1_q;
    assign bus.r_addr_2   = r_addr_2_q;
    assign bus.r_din_1    = r_din_1_q;
    assign bus.r_din_2    = r_din_2_q;

endmodule

// File: tb/tb_ntt_basemul.sv
// tb_ntt_basemul
//   Self-checking bench for ntt_basemul: RAM/ROM models, directed pair table,
//   full-memory patterns, randomized runs against an arithmetic reference,
//   mid-run start/reset sequences and a direct check of mod_q_reduce.
module tb_ntt_basemul;
    import ntt_basemul_pkg::*;

    localparam longint Q = 3329;

    typedef struct {
        string       name;
        int          pair;
        logic [15:0] a0, a1, b0, b1;
        int          exp0, exp1;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_basemul_if bus ();

    ntt_basemul dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [24:0] red_in;
    logic [11:0] red_out;
    mod_q_reduce u_red (.din(red_in), .dout(red_out));

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] mem_c [256];
    logic [15:0] gamma_rom [128];
    int          ref_a [256];
    int          ref_b [256];
    int          exp_c [256];
    bit          in_place;

    int checks;
    int failures;

    int we_count, first_we, last_we, done_count, done_cycle, busy_count, busy_last;

    vec_t vecs [8];

    // Synchronous RAM/ROM models; result writes optionally alias onto A.
    always @(posedge clk) begin
        bus.a_dout_1   <= mem_a[bus.src_addr_1];
        bus.a_dout_2   <= mem_a[bus.src_addr_2];
        bus.b_dout_1   <= mem_b[bus.src_addr_1];
        bus.b_dout_2   <= mem_b[bus.src_addr_2];
        bus.gamma_data <= gamma_rom[bus.gamma_addr];
        if (bus.r_we) begin
            mem_c[bus.r_addr_1] <= bus.r_din_1;
            mem_c[bus.r_addr_2] <= bus.r_din_2;
            if (in_place) begin
                mem_a[bus.r_addr_1] <= bus.r_din_1;
                mem_a[bus.r_addr_2] <= bus.r_din_2;
            end
        end
    end

    function automatic int brv7(int x);
        int r = 0;
        for (int k = 0; k < 7; k++) r = (r << 1) | ((x >> k) & 1);
        return r;
    endfunction

    function automatic int modpow(int base, int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = (r * base) % Q;
        return int'(r);
    endfunction

    function automatic int refEven(int a0, int a1, int b0, int b1, int g);
        return int'((longint'(a0) * b0 + longint'(a1) * b1 * g) % Q);
    endfunction

    function automatic int refOdd(int a0, int a1, int b0, int b1);
        return int'((longint'(a0) * b1 + longint'(a1) * b0) % Q);
    endfunction

    function automatic vec_t mkVec(string n, int p, logic [15:0] a0, logic [15:0] a1,
                                   logic [15:0] b0, logic [15:0] b1, int e0, int e1);
        vec_t v;
        v.name = n; v.pair = p;
        v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
        v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic checkOutput(string name, longint actual, longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulses start, then observes 140 cycles counted from the start edge.
    // Optionally re-pulses start or asserts reset at a chosen cycle.
    task automatic applyStimulus(int start_at, int reset_at);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        we_count   = 0;  first_we = -1; last_we = -1;
        done_count = 0;  done_cycle = -1;
        busy_count = 0;  busy_last = -1;
        for (int c = 0; c < 140; c++) begin
            bus.start = (c == start_at);
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                checkOutput("midrun_reset_busy", bus.busy, 0);
                checkOutput("midrun_reset_r_we", bus.r_we, 0);
                checkOutput("midrun_reset_done", bus.done, 0);
                #1;
                reset = 1'b0;
            end
            if (bus.r_we) begin
                we_count++;
                if (first_we < 0) first_we = c;
                last_we = c;
            end
            if (bus.done) begin
                done_count++;
                done_cycle = c;
            end
            if (bus.busy) begin
                busy_count++;
                busy_last = c;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic checkTiming(string tag);
        checkOutput({tag, "_we_count"}, we_count, 128);
        checkOutput({tag, "_first_we"}, first_we, PIPE_LAT);
        checkOutput({tag, "_last_we"}, last_we, 133);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_done_cycle"}, done_cycle, 134);
        checkOutput({tag, "_busy_count"}, busy_count, 134);
        checkOutput({tag, "_busy_last"}, busy_last, 133);
    endtask

    // Random operands (with junk in the ignored upper nibble) vs reference.
    task automatic runRandom(string tag, bit alias_a, int start_at);
        for (int i = 0; i < 256; i++) begin
            ref_a[i] = $urandom_range(0, 3328);
            ref_b[i] = $urandom_range(0, 3328);
            mem_a[i] = 16'(ref_a[i]) | (16'($urandom_range(0, 15)) << 12);
            mem_b[i] = 16'(ref_b[i]) | (16'($urandom_range(0, 15)) << 12);
            mem_c[i] = 16'hDEAD;
        end
        for (int p = 0; p < 128; p++) begin
            exp_c[2*p]   = refEven(ref_a[2*p], ref_a[2*p+1], ref_b[2*p], ref_b[2*p+1],
                                   modpow(17, 2 * brv7(p) + 1));
            exp_c[2*p+1] = refOdd(ref_a[2*p], ref_a[2*p+1], ref_b[2*p], ref_b[2*p+1]);
        end
        in_place = alias_a;
        applyStimulus(start_at, -1);
        in_place = 1'b0;
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_done_cycle"}, done_cycle, 134);
        for (int i = 0; i < 256; i++) begin
            checkOutput($sformatf("%s_c%0d", tag, i), mem_c[i], exp_c[i]);
            if (alias_a) checkOutput($sformatf("%s_alias_a%0d", tag, i), mem_a[i], exp_c[i]);
        end
    endtask

    initial begin
        automatic int nonzero;
        automatic int ks [8] = '{0, 1, 2, 3, 1000, 5000, 10078, 10079};
        automatic int v;

        checks    = 0;
        failures  = 0;
        in_place  = 1'b0;
        bus.start = 1'b0;
        reset     = 1'b1;
        red_in    = '0;
        for (int i = 0; i < 128; i++) gamma_rom[i] = 16'(modpow(17, 2 * brv7(i) + 1));

        vecs[0] = mkVec("unit_a0",       0,   16'd1,    16'd0,    16'd5,    16'd7,    5,    7);
        vecs[1] = mkVec("gamma0",        0,   16'd0,    16'd1,    16'd0,    16'd1,    17,   0);
        vecs[2] = mkVec("gamma64",       64,  16'd0,    16'd1,    16'd0,    16'd1,    1584, 0);
        vecs[3] = mkVec("gamma1",        1,   16'd0,    16'd1,    16'd0,    16'd1,    3312, 0);
        vecs[4] = mkVec("small",         0,   16'd2,    16'd3,    16'd4,    16'd5,    263,  22);
        vecs[5] = mkVec("upper_ignored", 5,   16'hF001, 16'd0,    16'hA005, 16'd0,    5,    0);
        vecs[6] = mkVec("max_cross",     127, 16'd3328, 16'd0,    16'd3328, 16'd3328, 1,    1);
        vecs[7] = mkVec("max_all",       0,   16'd3328, 16'd3328, 16'd3328, 16'd3328, 18,   2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",       bus.busy,       0);
        checkOutput("reset_done",       bus.done,       0);
        checkOutput("reset_r_we",       bus.r_we,       0);
        checkOutput("reset_src_addr_1", bus.src_addr_1, 0);
        checkOutput("reset_src_addr_2", bus.src_addr_2, 0);
        checkOutput("reset_gamma_addr", bus.gamma_addr, 0);
        checkOutput("reset_r_addr_1",   bus.r_addr_1,   0);
        checkOutput("reset_r_addr_2",   bus.r_addr_2,   0);
        checkOutput("reset_r_din_1",    bus.r_din_1,    0);
        checkOutput("reset_r_din_2",    bus.r_din_2,    0);
        @(negedge clk);
        reset = 1'b0;

        // A all zero, B random: every result word zero, exact write window.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 16'($urandom);
            mem_c[i] = 16'hDEAD;
        end
        applyStimulus(-1, -1);
        checkTiming("zeroA");
        nonzero = 0;
        for (int i = 0; i < 256; i++) if (mem_c[i] != 16'd0) nonzero++;
        checkOutput("zeroA_nonzero_words", nonzero, 0);

        // Directed single-pair vectors.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = 16'hDEAD;
            end
            mem_a[2*vecs[t].pair]   = vecs[t].a0;
            mem_a[2*vecs[t].pair+1] = vecs[t].a1;
            mem_b[2*vecs[t].pair]   = vecs[t].b0;
            mem_b[2*vecs[t].pair+1] = vecs[t].b1;
            applyStimulus(-1, -1);
            checkOutput({vecs[t].name, "_c_even"}, mem_c[2*vecs[t].pair],   vecs[t].exp0);
            checkOutput({vecs[t].name, "_c_odd"},  mem_c[2*vecs[t].pair+1], vecs[t].exp1);
            nonzero = 0;
            for (int i = 0; i < 256; i++)
                if ((i >> 1) != vecs[t].pair && mem_c[i] != 16'd0) nonzero++;
            checkOutput({vecs[t].name, "_others"}, nonzero, 0);
            checkOutput({vecs[t].name, "_done_cycle"}, done_cycle, 134);
        end

        // All operands q-1: even words 1+gamma_i, odd words 2.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'd3328; mem_b[i] = 16'd3328; mem_c[i] = 16'hDEAD;
        end
        applyStimulus(-1, -1);
        checkTiming("allmax");
        for (int p = 0; p < 128; p++) begin
            checkOutput($sformatf("allmax_c%0d", 2*p), mem_c[2*p],
                        (1 + modpow(17, 2 * brv7(p) + 1)) % 3329);
            checkOutput($sformatf("allmax_c%0d", 2*p+1), mem_c[2*p+1], 2);
        end

        // Randomized runs: 8 x 128 pairs, one in place, one with a stray start.
        for (int r = 0; r < 8; r++) begin
            runRandom($sformatf("rand%0d", r), (r == 3), (r == 5) ? 40 : -1);
        end

        // Reset at cycle 50: writes stop at once and no done appears.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'($urandom_range(0, 3328));
            mem_b[i] = 16'($urandom_range(0, 3328));
        end
        applyStimulus(-1, 50);
        checkOutput("reset50_done_count", done_count, 0);
        checkOutput("reset50_we_count",   we_count,   44);
        checkOutput("reset50_last_we",    last_we,    49);
        checkOutput("reset50_busy_count", busy_count, 50);
        runRandom("after_reset", 1'b0, -1);
        checkTiming("after_reset");

        // Direct check of the reduction unit around multiples of q and range ends.
        for (int k = 0; k < 8; k++) begin
            for (int d = -1; d <= 1; d++) begin
                v = ks[k] * 3329 + d;
                if (v >= 0) begin
                    red_in = 25'(v);
                    #1;
                    checkOutput($sformatf("reduce_%0d", v), red_out, v % 3329);
                end
            end
        end
        for (int k = 0; k < 2000; k++) begin
            v = (k == 0) ? 33554431 : ((k == 1) ? 16777216 : int'($urandom & 32'h01FF_FFFF));
            red_in = 25'(v);
            #1;
            checkOutput($sformatf("reduce_%0d", v), red_out, v % 3329);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
